// File: rtl/decode_stage.sv
// RV32I decode stage: 32x32 register file plus opcode/immediate decode,
// all results registered into the decode/execute (C) pipeline register.
module decode_stage #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [31:0]             InstrB,
   input  logic [DATA_WIDTH-1:0]   PCB,
   input  logic [DATA_WIDTH-1:0]   PCPlus4B,
   input  logic                    WrEnE,
   input  logic [4:0]              WrAddrE,
   input  logic [DATA_WIDTH-1:0]   WrDataE,
   output logic [DATA_WIDTH-1:0]   PCC,
   output logic [DATA_WIDTH-1:0]   PCPlus4C,
   output logic                    RegWriteC,
   output logic                    MemWriteC,
   output logic                    JumpC,
   output logic                    BranchC,
   output logic [1:0]              ALUSrcC,
   output logic [1:0]              ResultSrcC,
   output logic [1:0]              ALUOpC,
   output logic                    LinkRegCtrlC,
   output logic [DATA_WIDTH-1:0]   ImmExtC,
   output logic [DATA_WIDTH-1:0]   RData1C,
   output logic [DATA_WIDTH-1:0]   RData2C,
   output logic [4:0]              RdC,
   output logic [4:0]              Rs1C,
   output logic [4:0]              Rs2C,
   output logic [6:0]              Funct7C,
   output logic [2:0]              Funct3C
);

   localparam int unsigned DW   = DATA_WIDTH;
   localparam int unsigned AW   = 5;
   localparam int unsigned NREG = 32;

   localparam logic [6:0] OP_R     = 7'b0110011;
   localparam logic [6:0] OP_I     = 7'b0010011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;

   // ---------------------------------------------------------------------
   // Register file
   // ---------------------------------------------------------------------
   logic [DW-1:0] regs_q [NREG];
   logic [DW-1:0] regs_d [NREG];
   logic          wr_hit;

   assign wr_hit = WrEnE && (WrAddrE != AW'(0));

   always_comb begin
      regs_d = regs_q;
      if (wr_hit) begin
         regs_d[WrAddrE] = WrDataE;
      end
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         for (int i = 0; i < int'(NREG); i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         regs_q <= regs_d;
      end
   end

   // Reads see a same-cycle writeback so the C register never holds stale data.
   function automatic logic [DW-1:0] rf_read(input logic [AW-1:0] addr);
      logic [DW-1:0] val;
      if (addr == AW'(0)) begin
         val = '0;
      end else if (wr_hit && (WrAddrE == addr)) begin
         val = WrDataE;
      end else begin
         val = regs_q[addr];
      end
      return val;
   endfunction

   // ---------------------------------------------------------------------
   // Field extraction and control decode
   // ---------------------------------------------------------------------
   logic [6:0]    opcode;
   logic [AW-1:0] rd_f;
   logic [AW-1:0] rs1_f;
   logic [AW-1:0] rs2_f;
   logic          sgn;

   assign opcode = InstrB[6:0];
   assign rd_f   = InstrB[11:7];
   assign rs1_f  = InstrB[19:15];
   assign rs2_f  = InstrB[24:20];
   assign sgn    = InstrB[31];

   logic          reg_write_d,  reg_write_q;
   logic          mem_write_d,  mem_write_q;
   logic          jump_d,       jump_q;
   logic          branch_d,     branch_q;
   logic [1:0]    alu_src_d,    alu_src_q;
   logic [1:0]    result_src_d, result_src_q;
   logic [1:0]    alu_op_d,     alu_op_q;
   logic          link_d,       link_q;
   logic [DW-1:0] imm_d,        imm_q;

   // Unknown opcodes decode to a bubble: every control bit stays low.
   always_comb begin
      reg_write_d  = 1'b0;
      mem_write_d  = 1'b0;
      jump_d       = 1'b0;
      branch_d     = 1'b0;
      alu_src_d    = 2'b00;
      result_src_d = 2'b00;
      alu_op_d     = 2'b00;
      link_d       = 1'b0;
      unique case (opcode)
         OP_R: begin
            reg_write_d = 1'b1;
            alu_op_d    = 2'b10;
         end
         OP_I: begin
            reg_write_d = 1'b1;
            alu_src_d   = 2'b01;
            alu_op_d    = 2'b11;
         end
         OP_LOAD: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 2'b01;
            result_src_d = 2'b01;
         end
         OP_STORE: begin
            mem_write_d = 1'b1;
            alu_src_d   = 2'b01;
         end
         OP_BR: begin
            branch_d = 1'b1;
            alu_op_d = 2'b01;
         end
         OP_JAL: begin
            reg_write_d  = 1'b1;
            jump_d       = 1'b1;
            alu_src_d    = 2'b01;
            result_src_d = 2'b10;
         end
         OP_JALR: begin
            reg_write_d  = 1'b1;
            jump_d       = 1'b1;
            alu_src_d    = 2'b01;
            result_src_d = 2'b10;
            link_d       = 1'b1;
         end
         OP_LUI: begin
            reg_write_d  = 1'b1;
            alu_src_d    = 2'b01;
            result_src_d = 2'b11;
         end
         OP_AUIPC: begin
            reg_write_d = 1'b1;
            alu_src_d   = 2'b11;
         end
         default: ;
      endcase
   end

   // Immediate generation; the format is implied by the opcode.
   always_comb begin
      imm_d = '0;
      unique case (opcode)
         OP_I, OP_LOAD, OP_JALR:
            imm_d = {{(DW-12){sgn}}, InstrB[31:20]};
         OP_STORE:
            imm_d = {{(DW-12){sgn}}, InstrB[31:25], InstrB[11:7]};
         OP_BR:
            imm_d = {{(DW-13){sgn}}, InstrB[31], InstrB[7], InstrB[30:25],
                     InstrB[11:8], 1'b0};
         OP_LUI, OP_AUIPC:
            imm_d = {{(DW-32){sgn}}, InstrB[31:12], 12'h000};
         OP_JAL:
            imm_d = {{(DW-21){sgn}}, InstrB[31], InstrB[19:12], InstrB[20],
                     InstrB[30:21], 1'b0};
         default: ;
      endcase
   end

   // ---------------------------------------------------------------------
   // Data path into the C register
   // ---------------------------------------------------------------------
   logic [DW-1:0] pc_d,      pc_q;
   logic [DW-1:0] pc4_d,     pc4_q;
   logic [DW-1:0] rdata1_d,  rdata1_q;
   logic [DW-1:0] rdata2_d,  rdata2_q;
   logic [AW-1:0] rd_d,      rd_q;
   logic [AW-1:0] rs1_d,     rs1_q;
   logic [AW-1:0] rs2_d,     rs2_q;
   logic [6:0]    funct7_d,  funct7_q;
   logic [2:0]    funct3_d,  funct3_q;

   always_comb begin
      pc_d     = PCB;
      pc4_d    = PCPlus4B;
      rdata1_d = rf_read(rs1_f);
      rdata2_d = rf_read(rs2_f);
      rd_d     = rd_f;
      rs1_d    = rs1_f;
      rs2_d    = rs2_f;
      funct7_d = InstrB[31:25];
      funct3_d = InstrB[14:12];
   end

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         pc_q         <= '0;
         pc4_q        <= '0;
         reg_write_q  <= 1'b0;
         mem_write_q  <= 1'b0;
         jump_q       <= 1'b0;
         branch_q     <= 1'b0;
         alu_src_q    <= 2'b00;
         result_src_q <= 2'b00;
         alu_op_q     <= 2'b00;
         link_q       <= 1'b0;
         imm_q        <= '0;
         rdata1_q     <= '0;
         rdata2_q     <= '0;
         rd_q         <= '0;
         rs1_q        <= '0;
         rs2_q        <= '0;
         funct7_q     <= '0;
         funct3_q     <= '0;
      end else begin
         pc_q         <= pc_d;
         pc4_q        <= pc4_d;
         reg_write_q  <= reg_write_d;
         mem_write_q  <= mem_write_d;
         jump_q       <= jump_d;
         branch_q     <= branch_d;
         alu_src_q    <= alu_src_d;
         result_src_q <= result_src_d;
         alu_op_q     <= alu_op_d;
         link_q       <= link_d;
         imm_q        <= imm_d;
         rdata1_q     <= rdata1_d;
         rdata2_q     <= rdata2_d;
         rd_q         <= rd_d;
         rs1_q        <= rs1_d;
         rs2_q        <= rs2_d;
         funct7_q     <= funct7_d;
         funct3_q     <= funct3_d;
      end
   end

   assign PCC          = pc_q;
   assign PCPlus4C     = pc4_q;
   assign RegWriteC    = reg_write_q;
   assign MemWriteC    = mem_write_q;
   assign JumpC        = jump_q;
   assign BranchC      = branch_q;
   assign ALUSrcC      = alu_src_q;
   assign ResultSrcC   = result_src_q;
   assign ALUOpC       = alu_op_q;
   assign LinkRegCtrlC = link_q;
   assign ImmExtC      = imm_q;
   assign RData1C      = rdata1_q;
   assign RData2C      = rdata2_q;
   assign RdC          = rd_q;
   assign Rs1C         = rs1_q;
   assign Rs2C         = rs2_q;
   assign Funct7C      = funct7_q;
   assign Funct3C      = funct3_q;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a reference decoder and register-file
// model push expected C-register contents, compared one cycle later.
module tb_decode_stage;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] pc4;
      logic        regw;
      logic        memw;
      logic        jump;
      logic        br;
      logic [1:0]  alusrc;
      logic [1:0]  ressrc;
      logic [1:0]  aluop;
      logic        link;
      logic [31:0] imm;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [6:0]  f7;
      logic [2:0]  f3;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic [31:0] InstrB, PCB, PCPlus4B, WrDataE;
   logic        WrEnE;
   logic [4:0]  WrAddrE;
   logic [31:0] PCC, PCPlus4C, ImmExtC, RData1C, RData2C;
   logic        RegWriteC, MemWriteC, JumpC, BranchC, LinkRegCtrlC;
   logic [1:0]  ALUSrcC, ResultSrcC, ALUOpC;
   logic [4:0]  RdC, Rs1C, Rs2C;
   logic [6:0]  Funct7C;
   logic [2:0]  Funct3C;

   decode_stage #(.DATA_WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .InstrB(InstrB), .PCB(PCB), .PCPlus4B(PCPlus4B),
      .WrEnE(WrEnE), .WrAddrE(WrAddrE), .WrDataE(WrDataE),
      .PCC(PCC), .PCPlus4C(PCPlus4C), .RegWriteC(RegWriteC), .MemWriteC(MemWriteC),
      .JumpC(JumpC), .BranchC(BranchC), .ALUSrcC(ALUSrcC), .ResultSrcC(ResultSrcC),
      .ALUOpC(ALUOpC), .LinkRegCtrlC(LinkRegCtrlC), .ImmExtC(ImmExtC),
      .RData1C(RData1C), .RData2C(RData2C), .RdC(RdC), .Rs1C(Rs1C), .Rs2C(Rs2C),
      .Funct7C(Funct7C), .Funct3C(Funct3C)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int          asserts  = 0;
   int          failures = 0;
   exp_t        sb[$];
   logic [31:0] mregs [32];
   logic [31:0] pc_ctr = 32'h0000_1000;

   function automatic exp_t ref_decode(input logic [31:0] i, input logic [31:0] pc,
                                       input logic [31:0] r1, input logic [31:0] r2);
      exp_t        e;
      logic [10:0] c;
      e = '0;
      case (i[6:0])
         7'b0110011: c = 11'b1000_0000_100;
         7'b0010011: c = 11'b1000_0100_110;
         7'b0000011: c = 11'b1000_0101_000;
         7'b0100011: c = 11'b0100_0100_000;
         7'b1100011: c = 11'b0001_0000_010;
         7'b1101111: c = 11'b1010_0110_000;
         7'b1100111: c = 11'b1010_0110_001;
         7'b0110111: c = 11'b1000_0111_000;
         7'b0010111: c = 11'b1000_1100_000;
         default:    c = 11'b0;
      endcase
      {e.regw, e.memw, e.jump, e.br, e.alusrc, e.ressrc, e.aluop, e.link} = c;
      case (i[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: e.imm = 32'($signed(i[31:20]));
         7'b0100011: e.imm = 32'($signed({i[31:25], i[11:7]}));
         7'b1100011: e.imm = 32'($signed({i[31], i[7], i[30:25], i[11:8], 1'b0}));
         7'b0110111, 7'b0010111: e.imm = {i[31:12], 12'h000};
         7'b1101111: e.imm = 32'($signed({i[31], i[19:12], i[20], i[30:21], 1'b0}));
         default: e.imm = 32'h0;
      endcase
      e.pc  = pc;
      e.pc4 = pc + 32'd4;
      e.rd1 = r1;
      e.rd2 = r2;
      e.rd  = i[11:7];
      e.rs1 = i[19:15];
      e.rs2 = i[24:20];
      e.f7  = i[31:25];
      e.f3  = i[14:12];
      return e;
   endfunction

   function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                              input logic [4:0] wa, input logic [31:0] wd);
      if (a == 5'd0) return 32'h0;
      if (we && wa == a) return wd;
      return mregs[a];
   endfunction

   function automatic exp_t sample();
      exp_t o;
      o.pc = PCC; o.pc4 = PCPlus4C; o.regw = RegWriteC; o.memw = MemWriteC;
      o.jump = JumpC; o.br = BranchC; o.alusrc = ALUSrcC; o.ressrc = ResultSrcC;
      o.aluop = ALUOpC; o.link = LinkRegCtrlC; o.imm = ImmExtC; o.rd1 = RData1C;
      o.rd2 = RData2C; o.rd = RdC; o.rs1 = Rs1C; o.rs2 = Rs2C; o.f7 = Funct7C;
      o.f3 = Funct3C;
      return o;
   endfunction

   function automatic logic [31:0] rd_instr(input logic [4:0] a, input logic [4:0] b);
      return {7'b0, b, a, 3'b000, 5'd0, 7'b0110011};
   endfunction

   // Drive one instruction plus optional writeback, push its expectation, advance one edge.
   task automatic step(input logic [31:0] instr, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd);
      logic [31:0] r1, r2;
      r1 = model_read(instr[19:15], we, wa, wd);
      r2 = model_read(instr[24:20], we, wa, wd);
      sb.push_back(ref_decode(instr, pc_ctr, r1, r2));
      if (we && wa != 5'd0) mregs[wa] = wd;
      InstrB = instr; PCB = pc_ctr; PCPlus4B = pc_ctr + 32'd4;
      WrEnE = we; WrAddrE = wa; WrDataE = wd;
      pc_ctr = pc_ctr + 32'd4;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      exp_t o;
      rst_n = 1'b1;
      InstrB = 32'h0000_8133; PCB = 32'h40; PCPlus4B = 32'h44;
      WrEnE = 1'b0; WrAddrE = '0; WrDataE = '0;
      for (int k = 0; k < 32; k++) mregs[k] = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      o = sample();
      asserts++;
      if (o !== exp_t'(0)) begin
         failures++;
         $display("FAIL reset_outputs: got %h, required 0", o);
      end
      rst_n = 1'b0;
   endtask

   task automatic test_regfile();
      exp_t e, o;
      step(32'h0, 1'b1, 5'd1, 32'd658038);
      step(32'h0, 1'b1, 5'd2, 32'd900004);
      step(32'h0, 1'b1, 5'd3, 32'd444444);
      step(32'h0, 1'b1, 5'd15, 32'd1111111);
      step(32'h0, 1'b1, 5'd0, 32'd100);
      step(rd_instr(5'd1, 5'd2), 1'b0, 5'd0, 32'h0);
      step(rd_instr(5'd3, 5'd15), 1'b0, 5'd0, 32'h0);
      step(rd_instr(5'd0, 5'd0), 1'b0, 5'd0, 32'h0);
      while (sb.size() > 3) begin
         e = sb.pop_front();
         asserts++;
      end
      // The last three pops correspond to the read instructions, still on the outputs only for the last one.
      e = sb.pop_front();
      e = sb.pop_front();
      e = sb.pop_front();
      o = sample();
      asserts++;
      if (o !== e) begin
         failures++;
         $display("FAIL regfile_scoreboard: got %h, required %h", o, e);
      end
      asserts++;
      if (RData1C !== 32'd0 || RData2C !== 32'd0) begin
         failures++;
         $display("FAIL x0_reads_zero: got %0d/%0d, required 0/0", RData1C, RData2C);
      end
      step(rd_instr(5'd1, 5'd2), 1'b0, 5'd0, 32'h0);
      e = sb.pop_front();
      asserts++;
      if (RData1C !== 32'd658038 || RData2C !== 32'd900004) begin
         failures++;
         $display("FAIL x1_x2_readback: got %0d/%0d, required 658038/900004", RData1C, RData2C);
      end
      step(rd_instr(5'd3, 5'd15), 1'b0, 5'd0, 32'h0);
      e = sb.pop_front();
      asserts++;
      if (RData1C !== 32'd444444 || RData2C !== 32'd1111111) begin
         failures++;
         $display("FAIL x3_x15_readback: got %0d/%0d, required 444444/1111111", RData1C, RData2C);
      end
   endtask

   task automatic test_alu();
      exp_t e, o;
      step(32'h0000_8133, 1'b0, 5'd0, 32'h0);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e) begin
         failures++;
         $display("FAIL add_scoreboard: got %h, required %h", o, e);
      end
      asserts++;
      if ({RegWriteC, ALUOpC, ALUSrcC, RdC} !== {1'b1, 2'b10, 2'b00, 5'd2} ||
          RData1C !== 32'd658038 || RData2C !== 32'd0) begin
         failures++;
         $display("FAIL add_fields: got rw=%b op=%b src=%b rd=%0d r1=%0d r2=%0d, required 1 10 00 2 658038 0",
                  RegWriteC, ALUOpC, ALUSrcC, RdC, RData1C, RData2C);
      end
      step(32'h0F01_C213, 1'b0, 5'd0, 32'h0);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e) begin
         failures++;
         $display("FAIL xori_scoreboard: got %h, required %h", o, e);
      end
      asserts++;
      if (ImmExtC !== 32'h0000_00F0 || ALUOpC !== 2'b11 || ALUSrcC !== 2'b01 ||
          RData1C !== 32'd444444) begin
         failures++;
         $display("FAIL xori_fields: got imm=%h op=%b src=%b r1=%0d, required 000000f0 11 01 444444",
                  ImmExtC, ALUOpC, ALUSrcC, RData1C);
      end
   endtask

   task automatic test_store_branch_lui();
      exp_t e, o;
      step(32'h6CF0_10A3, 1'b0, 5'd0, 32'h0);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e) begin
         failures++;
         $display("FAIL sh_scoreboard: got %h, required %h", o, e);
      end
      asserts++;
      if (MemWriteC !== 1'b1 || RegWriteC !== 1'b0 || ImmExtC !== 32'h0000_06C1 ||
          RData2C !== 32'd1111111) begin
         failures++;
         $display("FAIL sh_fields: got mw=%b rw=%b imm=%h r2=%0d, required 1 0 000006c1 1111111",
                  MemWriteC, RegWriteC, ImmExtC, RData2C);
      end
      step(32'h8020_D1E3, 1'b0, 5'd0, 32'h0);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e || BranchC !== 1'b1 || ALUOpC !== 2'b01 || ImmExtC !== 32'hFFFF_F802) begin
         failures++;
         $display("FAIL bge: got br=%b op=%b imm=%h (%h), required 1 01 fffff802 (%h)",
                  BranchC, ALUOpC, ImmExtC, o, e);
      end
      step(32'hF0F0_F837, 1'b0, 5'd0, 32'h0);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e || ImmExtC !== 32'hF0F0_F000 || ResultSrcC !== 2'b11 || RdC !== 5'd16) begin
         failures++;
         $display("FAIL lui: got imm=%h rs=%b rd=%0d, required f0f0f000 11 16", ImmExtC, ResultSrcC, RdC);
      end
   endtask

   task automatic test_bypass();
      exp_t e, o;
      step(rd_instr(5'd5, 5'd0), 1'b1, 5'd5, 32'hDEAD_BEEF);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e || RData1C !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL bypass_x5: got %h, required deadbeef", RData1C);
      end
      step(rd_instr(5'd0, 5'd5), 1'b1, 5'd0, 32'd123);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e || RData1C !== 32'd0 || RData2C !== 32'hDEAD_BEEF) begin
         failures++;
         $display("FAIL bypass_x0: got %h/%h, required 0/deadbeef", RData1C, RData2C);
      end
   endtask

   task automatic test_back_to_back();
      exp_t        e, o;
      logic [31:0] instr;
      logic [6:0]  ops [10];
      int          bad;
      ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
              7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111, 7'b1111111};
      bad = 0;
      for (int n = 0; n < 60; n++) begin
         instr = $urandom;
         instr[6:0] = ops[$urandom_range(9)];
         step(instr, 1'($urandom_range(1)), 5'($urandom_range(31)), $urandom);
         e = sb.pop_front(); o = sample();
         asserts++;
         if (o !== e) begin
            failures++;
            if (bad < 5) $display("FAIL random_%0d instr=%h: got %h, required %h", n, instr, o, e);
            bad++;
         end
      end
   endtask

   task automatic test_jump_reset();
      exp_t e, o;
      step(32'h8010_0267, 1'b0, 5'd0, 32'h0);
      e = sb.pop_front(); o = sample();
      asserts++;
      if (o !== e || JumpC !== 1'b1 || LinkRegCtrlC !== 1'b1 || ResultSrcC !== 2'b10 ||
          ImmExtC !== 32'hFFFF_F801) begin
         failures++;
         $display("FAIL jalr: got j=%b l=%b rs=%b imm=%h, required 1 1 10 fffff801",
                  JumpC, LinkRegCtrlC, ResultSrcC, ImmExtC);
      end
      #2 rst_n = 1'b1;
      #1;
      o = sample();
      asserts++;
      if (o !== exp_t'(0)) begin
         failures++;
         $display("FAIL mid_reset_async: got %h, required 0", o);
      end
      for (int k = 0; k < 32; k++) mregs[k] = 32'h0;
      @(posedge clk);
      #1 rst_n = 1'b0;
      step(rd_instr(5'd1, 5'd15), 1'b0, 5'd0, 32'h0);
      e = sb.pop_front();
      asserts++;
      if (RData1C !== 32'd0 || RData2C !== 32'd0 || e.rd1 !== 32'd0) begin
         failures++;
         $display("FAIL regfile_cleared: got %h/%h, required 0/0", RData1C, RData2C);
      end
   endtask

   initial begin
      test_reset();
      test_regfile();
      test_alu();
      test_store_branch_lui();
      test_bypass();
      test_back_to_back();
      test_jump_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
      $finish;
   end

endmodule
